// File: rtl/fetch_stage_gen_if.sv
// Handshake and operand bundle between the PE main controller, the fetch stage and the multiply stage.
interface fetch_stage_gen_if #(
  parameter int ROWS    = 4,
  parameter int DWD     = 16,
  parameter int PSUMDWD = 32,
  parameter int MASKW   = 64,
  parameter int NUMTW   = 4,
  parameter int SSW     = 8,
  parameter int MODEW   = 3
);
  logic                      MAIN_rdy;
  logic                      MAIN_ack;
  logic                      FS_rdy;
  logic                      FS_ack;
  logic [MODEW-1:0]          i_mode;
  logic [NUMTW-1:0]          i_inumt;
  logic [NUMTW-1:0]          i_wnumt;
  logic [SSW-1:0]            i_ssctl;
  logic                      i_psum_d16;
  logic                      i_psum_parity;
  logic [ROWS*DWD-1:0]       i_input;
  logic [ROWS*DWD-1:0]       i_weight;
  logic [ROWS*PSUMDWD-1:0]   i_psum;
  logic [ROWS*DWD-1:0]       o_input;
  logic [ROWS*DWD-1:0]       o_weight;
  logic [ROWS*PSUMDWD-1:0]   o_psum;
  logic [MASKW-1:0]          o_mask;
  logic [MODEW-1:0]          o_mode;
  logic [NUMTW-1:0]          o_inumt;
  logic [NUMTW-1:0]          o_wnumt;
  logic [SSW-1:0]            o_ssctl;
  logic                      o_err_mode;

  modport slave (
    input  MAIN_rdy, FS_ack, i_mode, i_inumt, i_wnumt, i_ssctl, i_psum_d16, i_psum_parity,
           i_input, i_weight, i_psum,
    output MAIN_ack, FS_rdy, o_input, o_weight, o_psum, o_mask, o_mode, o_inumt, o_wnumt,
           o_ssctl, o_err_mode
  );

  modport master (
    output MAIN_rdy, FS_ack, i_mode, i_inumt, i_wnumt, i_ssctl, i_psum_d16, i_psum_parity,
           i_input, i_weight, i_psum,
    input  MAIN_ack, FS_rdy, o_input, o_weight, o_psum, o_mask, o_mode, o_inumt, o_wnumt,
           o_ssctl, o_err_mode
  );
endinterface

// File: rtl/fetch_stage_gen.sv
// Fetch stage: registers row operands, derives the AU lane mask, applies D16 psum half select.
// Define FS_SKID_EN for a 2-entry skid buffer with a registered MAIN_ack.
module fetch_stage_gen #(
  parameter int ROWS    = 4,
  parameter int DWD     = 16,
  parameter int PSUMDWD = 32,
  parameter int LANES   = 4,
  parameter int NUMTW   = 4,
  parameter int SSW     = 8,
  parameter int MODEW   = 3
) (
  input logic              i_clk,
  input logic              i_rst,
  fetch_stage_gen_if.slave bus
);
  localparam int MASKW = 64;
  localparam int LW    = MASKW / LANES;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [MASKW-1:0]        mask;
    logic [MODEW-1:0]        mode;
    logic [NUMTW-1:0]        inumt;
    logic [NUMTW-1:0]        wnumt;
    logic [SSW-1:0]          ssctl;
    logic [ROWS*DWD-1:0]     inp;
    logic [ROWS*DWD-1:0]     wgt;
    logic [ROWS*PSUMDWD-1:0] psum;
  } beat_t;

  function automatic logic [MASKW-1:0] lane_mask(input logic [MODEW-1:0] m);
    logic [MASKW-1:0] ones;
    ones = {{(MASKW-LW){1'b0}}, {LW{1'b1}}};
    if (int'(m) == 0)          return ones;
    else if (int'(m) <= LANES) return ones << (LW * (int'(m) - 1));
    else                       return '0;
  endfunction

  // Upper-half select for D16 partial sums: each row is shifted down by one operand width.
  function automatic logic [ROWS*PSUMDWD-1:0] psum_sel(input logic [ROWS*PSUMDWD-1:0] p,
                                                       input logic d16, input logic par);
    logic [ROWS*PSUMDWD-1:0] r;
    r = p;
    if (d16 && par) begin
      for (int k = 0; k < ROWS; k++) r[k*PSUMDWD +: PSUMDWD] = p[k*PSUMDWD +: PSUMDWD] >> DWD;
    end
    return r;
  endfunction

  state_t state_q, state_d;
  beat_t  out_q, out_d, in_beat;
  logic   err_q, err_d;
  logic   main_xfer, fs_xfer, fs_rdy;
`ifdef FS_SKID_EN
  beat_t  skid_q, skid_d;
  logic   ack_q;
`endif

  always_comb begin
    in_beat.mask  = lane_mask(bus.i_mode);
    in_beat.mode  = bus.i_mode;
    in_beat.inumt = bus.i_inumt;
    in_beat.wnumt = bus.i_wnumt;
    in_beat.ssctl = bus.i_ssctl;
    in_beat.inp   = bus.i_input;
    in_beat.wgt   = bus.i_weight;
    in_beat.psum  = psum_sel(bus.i_psum, bus.i_psum_d16, bus.i_psum_parity);
  end

  assign fs_rdy    = (state_q != EMPTY);
  assign main_xfer = bus.MAIN_rdy && bus.MAIN_ack;
  assign fs_xfer   = fs_rdy && bus.FS_ack;

`ifdef FS_SKID_EN
  assign bus.MAIN_ack = ack_q;
`else
  assign bus.MAIN_ack = !fs_rdy || bus.FS_ack;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef FS_SKID_EN
    skid_d  = skid_q;
`endif
    err_d   = err_q || (main_xfer && (int'(bus.i_mode) > LANES));
    case (state_q)
      EMPTY: begin
        if (main_xfer) begin
          out_d   = in_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (main_xfer && fs_xfer) out_d = in_beat;
        else if (fs_xfer)         state_d = EMPTY;
`ifdef FS_SKID_EN
        else if (main_xfer) begin
          skid_d  = in_beat;
          state_d = TWO;
        end
`endif
      end
      TWO: begin
`ifdef FS_SKID_EN
        if (fs_xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
`else
        state_d = EMPTY;
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  // Register boundary: output stage (plus skid entry when enabled)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      err_q   <= 1'b0;
`ifdef FS_SKID_EN
      skid_q  <= '0;
      ack_q   <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
`ifdef FS_SKID_EN
      skid_q  <= skid_d;
      ack_q   <= (state_d != TWO);
`endif
    end
  end

  assign bus.FS_rdy     = fs_rdy;
  assign bus.o_mask     = out_q.mask;
  assign bus.o_mode     = out_q.mode;
  assign bus.o_inumt    = out_q.inumt;
  assign bus.o_wnumt    = out_q.wnumt;
  assign bus.o_ssctl    = out_q.ssctl;
  assign bus.o_input    = out_q.inp;
  assign bus.o_weight   = out_q.wgt;
  assign bus.o_psum     = out_q.psum;
  assign bus.o_err_mode = err_q;
endmodule

// File: tb/tb_fetch_stage_gen.sv
// Randomized bench for fetch_stage_gen with a queue-based reference model of accepted beats.
module tb_fetch_stage_gen;
`ifdef FS_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   tx;
  int   rx;
  bit   acc;
  bit   m_err;

  typedef struct {
    logic [63:0]  mask;
    logic [2:0]   mode;
    logic [3:0]   inumt;
    logic [3:0]   wnumt;
    logic [7:0]   ssctl;
    logic [63:0]  inp;
    logic [63:0]  wgt;
    logic [127:0] psum;
  } exp_t;

  exp_t q[$];

  fetch_stage_gen_if #(.ROWS(4), .DWD(16), .PSUMDWD(32), .MASKW(64), .NUMTW(4), .SSW(8), .MODEW(3)) bus();

  fetch_stage_gen #(.ROWS(4), .DWD(16), .PSUMDWD(32), .LANES(4), .NUMTW(4), .SSW(8), .MODEW(3))
    dut (.i_clk(clk), .i_rst(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model_beat();
    exp_t e;
    int   md;
    md = int'(bus.i_mode);
    e.mask = '0;
    if (md == 0) e.mask[15:0] = 16'hffff;
    else if (md <= 4) e.mask[(md-1)*16 +: 16] = 16'hffff;
    e.mode  = bus.i_mode;
    e.inumt = bus.i_inumt;
    e.wnumt = bus.i_wnumt;
    e.ssctl = bus.i_ssctl;
    e.inp   = bus.i_input;
    e.wgt   = bus.i_weight;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] p;
      p = bus.i_psum[r*32 +: 32];
      if (bus.i_psum_d16 && bus.i_psum_parity) p = p / 32'd65536;
      e.psum[r*32 +: 32] = p;
    end
    return e;
  endfunction

  task automatic new_beat(input logic [2:0] mode, input logic [7:0] ss);
    bus.i_mode        = mode;
    bus.i_ssctl       = ss;
    bus.i_inumt       = 4'($urandom);
    bus.i_wnumt       = 4'($urandom);
    bus.i_psum_d16    = 1'($urandom);
    bus.i_psum_parity = 1'($urandom);
    bus.i_input       = {$urandom, $urandom};
    bus.i_weight      = {$urandom, $urandom};
    bus.i_psum        = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fs_rdy"}, 128'(bus.FS_rdy), 128'd0);
    chk({tag, "_main_ack"}, 128'(bus.MAIN_ack), 128'd1);
    chk({tag, "_mask"}, 128'(bus.o_mask), 128'd0);
    chk({tag, "_ssctl"}, 128'(bus.o_ssctl), 128'd0);
    chk({tag, "_mode"}, 128'(bus.o_mode), 128'd0);
    chk({tag, "_nums"}, 128'({bus.o_inumt, bus.o_wnumt}), 128'd0);
    chk({tag, "_inp_wgt"}, 128'({bus.o_input, bus.o_weight}), 128'd0);
    chk({tag, "_psum"}, 128'(bus.o_psum), 128'd0);
    chk({tag, "_err"}, 128'(bus.o_err_mode), 128'd0);
  endtask

  // One clock: compare against the model at the falling edge, then update it.
  task automatic cycle();
    bit mx;
    bit fx;
    bit ack_exp;
    @(negedge clk);
    mx = bus.MAIN_rdy && bus.MAIN_ack;
    fx = bus.FS_rdy && bus.FS_ack;
    ack_exp = SKID ? (q.size() < 2) : (q.size() == 0 || bus.FS_ack);
    chk("fs_rdy", 128'(bus.FS_rdy), 128'(q.size() > 0));
    chk("main_ack", 128'(bus.MAIN_ack), 128'(ack_exp));
    chk("err_mode", 128'(bus.o_err_mode), 128'(m_err));
    if (q.size() > 0) begin
      chk("o_ssctl", 128'(bus.o_ssctl), 128'(q[0].ssctl));
      chk("o_mask", 128'(bus.o_mask), 128'(q[0].mask));
      chk("o_mode_nums", 128'({bus.o_mode, bus.o_inumt, bus.o_wnumt}),
          128'({q[0].mode, q[0].inumt, q[0].wnumt}));
      chk("o_inp_wgt", 128'({bus.o_input, bus.o_weight}), 128'({q[0].inp, q[0].wgt}));
      chk("o_psum", bus.o_psum, q[0].psum);
    end
    if (fx && q.size() > 0) begin
      void'(q.pop_front());
      rx++;
    end
    if (mx) begin
      q.push_back(model_beat());
      tx++;
      if (bus.i_mode > 3'd4) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
    acc = mx;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    q.delete();
    m_err = 1'b0;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bus.MAIN_rdy = 1'b0;
    bus.FS_ack   = 1'b1;
    for (int i = 0; i < budget && q.size() > 0; i++) cycle();
    chk("drain_empty", 128'(q.size()), 128'd0);
  endtask

  logic [63:0] mt [1:4];

  initial begin
    n_chk = 0; n_err = 0; tx = 0; rx = 0; acc = 1'b0; m_err = 1'b0;
    mt[1] = 64'h0000_0000_0000_ffff;
    mt[2] = 64'h0000_0000_ffff_0000;
    mt[3] = 64'h0000_ffff_0000_0000;
    mt[4] = 64'hffff_0000_0000_0000;
    bus.MAIN_rdy = 1'b0;
    bus.FS_ack   = 1'b0;
    new_beat(3'd0, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single D16 beat, upper half selected
    new_beat(3'd0, 8'h11);
    bus.i_psum_d16    = 1'b1;
    bus.i_psum_parity = 1'b1;
    bus.i_psum[31:0]  = 32'h1234_5678;
    bus.MAIN_rdy      = 1'b1;
    cycle();
    bus.MAIN_rdy = 1'b0;
    chk("d16_accept", 128'(acc), 128'd1);
    chk("d16_fs_rdy", 128'(bus.FS_rdy), 128'd1);
    chk("d16_mask", 128'(bus.o_mask), 128'h0000_0000_0000_ffff);
    chk("d16_psum_row0", 128'(bus.o_psum[31:0]), 128'h0000_1234);
    drain(10);

    // Modes 1..4 back to back
    bus.FS_ack   = 1'b1;
    bus.MAIN_rdy = 1'b1;
    for (int m = 1; m <= 4; m++) begin
      new_beat(3'(m), 8'(m));
      cycle();
      chk("mode_accept", 128'(acc), 128'd1);
      chk("mode_mask", 128'(bus.o_mask), 128'(mt[m]));
    end
    drain(10);

    // Illegal mode, then legal beats: flag sticks until reset
    bus.MAIN_rdy = 1'b1;
    new_beat(3'd5, 8'h55);
    cycle();
    chk("bad_mask", 128'(bus.o_mask), 128'd0);
    chk("bad_err", 128'(bus.o_err_mode), 128'd1);
    for (int i = 0; i < 10; i++) begin
      new_beat(3'($urandom_range(0, 4)), 8'(i));
      cycle();
    end
    drain(10);
    chk("err_sticky", 128'(bus.o_err_mode), 128'd1);
    do_reset();

    // Stall with three queued beats
    begin
      int k;
      k = 0;
      bus.FS_ack   = 1'b0;
      bus.MAIN_rdy = 1'b1;
      new_beat(3'd1, 8'hA0);
      for (int i = 0; i < 5; i++) begin
        cycle();
        if (acc) begin
          k++;
          if (k < 3) new_beat(3'(k + 1), 8'(8'hA0 + k));
          else bus.MAIN_rdy = 1'b0;
        end
      end
      chk("stall_accepted", 128'(k), SKID ? 128'd2 : 128'd1);
      bus.FS_ack = 1'b1;
      for (int i = 0; i < 20 && (k < 3 || q.size() > 0); i++) begin
        cycle();
        if (acc) begin
          k++;
          if (k < 3) new_beat(3'(k + 1), 8'(8'hA0 + k));
          else bus.MAIN_rdy = 1'b0;
        end
      end
      bus.MAIN_rdy = 1'b0;
      chk("stall_all_sent", 128'(k), 128'd3);
      chk("stall_drained", 128'(q.size()), 128'd0);
    end

    // Random handshake traffic, incrementing side-band
    begin
      int sent;
      int rx0;
      sent = 0;
      rx0  = rx;
      new_beat(3'($urandom_range(0, 4)), 8'(sent));
      for (int c = 0; c < 20000 && (sent < 1000 || q.size() > 0); c++) begin
        bus.MAIN_rdy = (sent < 1000) && ($urandom_range(0, 3) != 0);
        bus.FS_ack   = ($urandom_range(0, 2) != 0);
        cycle();
        if (acc) begin
          sent++;
          new_beat(3'($urandom_range(0, 4)), 8'(sent));
        end
      end
      bus.MAIN_rdy = 1'b0;
      chk("rand_sent", 128'(sent), 128'd1000);
      chk("rand_received", 128'(rx - rx0), 128'd1000);
    end

    // Reset while holding beats
    bus.FS_ack   = 1'b0;
    bus.MAIN_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_beat(3'($urandom_range(1, 4)), 8'(8'hC0 + i));
      cycle();
    end
    bus.MAIN_rdy = 1'b0;
    chk("held_before_reset", 128'(q.size()), SKID ? 128'd2 : 128'd1);
    do_reset();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_stage_gen.md
# fetch_stage_gen

Parametrised fetch stage between the PE main controller and the multiply stage. It registers per-row input, weight and partial-sum operands and derives the arithmetic-unit lane mask from the layer mode. It applies D16 partial-sum parity selection to the registered data and passes the multiply-stage configuration downstream over rdy/ack handshakes. Row count, data widths and lane count are generic, and an optional 2-entry skid buffer removes the combinational ready path.

## Interface
Parameters:
- ROWS, 4, PE rows served
- DWD, 16, input/weight width
- PSUMDWD, 32, psum width (≥ 2*DWD)
- LANES, 4, AU lanes; mask width MASKW = 64, lane width MASKW/LANES
- NUMTW, 4, width of iNumT/wNumT
- SSW, 8, width of opaque ssctl side-band
- MODEW, 3, mode width; mode 0 = XNOR

Ports (one clock; reset asynchronous, active-low):
- i_clk  in  1  clock
- i_rst  in  1  async reset, active low
- MAIN_rdy  in  1  upstream beat valid
- MAIN_ack  out  1  upstream beat accepted
- FS_rdy  out  1  downstream beat valid
- FS_ack  in  1  downstream accepts
- i_mode  in  MODEW  layer mode
- i_inumt, i_wnumt  in  NUMTW each  tile counts, passed through
- i_ssctl  in  SSW  side-band, passed through
- i_psum_d16  in  1  1 = D16 psum mode
- i_psum_parity  in  1  D16 half select
- i_input, i_weight  in  ROWS*DWD  row r at [r*DWD +: DWD]
- i_psum  in  ROWS*PSUMDWD  row r at [r*PSUMDWD +: PSUMDWD]
- o_input, o_weight, o_psum  out  same widths  registered operands
- o_mask  out  MASKW  AU lane mask
- o_mode, o_inumt, o_wnumt, o_ssctl  out  registered pass-through
- o_err_mode  out  1  sticky illegal-mode flag

## Operation
- Transfer on a port occurs in any cycle with rdy && ack. All control and data inputs are sampled only on a MAIN transfer.
- Mask: mode 0 → lane 0 ones (16'hffff in bits [15:0]); mode k in 1..LANES → lane k-1 all ones; mode > LANES → mask 0 and o_err_mode set.
- Psum per row: if i_psum_d16 && i_psum_parity → i_psum >> DWD (zero-filled); otherwise i_psum unmodified.
- o_err_mode: set on a MAIN transfer with an illegal mode. It stays set until reset.
- Storage states: EMPTY (FS_rdy=0), ONE (FS_rdy=1, output reg valid), TWO (skid build only, output reg and skid reg valid).
  - EMPTY + MAIN xfer → ONE.
  - ONE + MAIN xfer without FS xfer → TWO (skid build) or hold with MAIN_ack=0 (non-skid build).
  - ONE + FS xfer without MAIN xfer → EMPTY.
  - ONE + both → ONE; the new beat loads the output reg.
  - TWO + FS xfer → ONE; the skid reg moves to the output reg. MAIN_ack=0 in TWO.
- Beat order is strictly preserved. No beat is dropped or duplicated.
- Reset mid-operation discards all held beats.

## Timing
- Reset values: all outputs 0, FS_rdy=0, MAIN_ack=1 (skid) or MAIN_ack=1 (non-skid, since FS_rdy=0), state EMPTY.
- Latency: 1 cycle. A beat accepted in cycle n appears with FS_rdy=1 in cycle n+1.
- Throughput: 1 beat/cycle while FS_ack is held high.
- Outputs change only on a MAIN transfer into the output reg or a skid move. They hold stable while FS_rdy && !FS_ack.
- Non-skid MAIN_ack = !FS_rdy || FS_ack (combinational from FS_ack).
- Skid MAIN_ack = (state != TWO), driven from a register only.

## Configuration
- FS_SKID_EN defined: 2-entry skid buffer (states EMPTY/ONE/TWO). MAIN_ack has no combinational path from FS_ack. Up to 2 beats are buffered.
- FS_SKID_EN undefined: single register stage (EMPTY/ONE only). MAIN_ack = !FS_rdy || FS_ack. Data path is identical.

## Test plan
- Reset, then one beat with mode 0, ROWS=4, psum row0=32'h1234_5678, d16=1, parity=1 → next cycle FS_rdy=1, o_mask=64'h0000_0000_0000_ffff, o_psum row0=32'h0000_1234.
- Modes 1..4 in consecutive beats with FS_ack=1 → masks 64'h…ffff, …ffff_0000, 64'h0000_ffff_0000_0000, 64'hffff_0000_0000_0000, one per cycle, no bubbles.
- Mode 5 beat → o_mask=0 and o_err_mode=1. It stays 1 after 10 further legal beats and clears only on i_rst low.
- FS_ack held 0 for 5 cycles while MAIN_rdy=1 with beats A,B,C:
  - skid build: accepts A,B, then MAIN_ack=0.
  - non-skid build: accepts A only.
  - on FS_ack=1, outputs A,B,C in order, with outputs stable during the stall.
- Random rdy/ack toggling, 1000 beats with incrementing i_ssctl → o_ssctl sequence identical, no loss or duplication.
- Assert i_rst low while in state TWO → next cycle FS_rdy=0, all outputs 0, MAIN_ack=1.
